insn_mem: RTL and testbench
===========================

INSN_MEM -- requirements
Module: insn_mem

Interface
REQ-001 Parameter DWIDTH, default 32: instruction/data word width in bits.
REQ-002 Parameter AWIDTH, default 32: byte-address width in bits.
REQ-003 Parameter BASEADDR, default 32'h01000000: byte address of word 0.
REQ-004 Parameter DEPTH, default 1024: number of DWIDTH words stored.
REQ-005 Parameter LATENCY, default 2, legal range 1..4: cycles from request acceptance to earliest rsp_valid_o.
REQ-006 Parameter QDEPTH, default 4, legal range >= LATENCY: maximum outstanding requests.
REQ-007 clk  input  1  sole clock, rising-edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 req_valid_i  input  1  fetch request present.
REQ-010 req_ready_o  output  1  request can be accepted this cycle.
REQ-011 req_addr_i  input  AWIDTH  fetch byte address (pc).
REQ-012 rsp_valid_o  output  1  response word present.
REQ-013 rsp_ready_i  input  1  fetch consumes response this cycle.
REQ-014 rsp_data_o  output  DWIDTH  instruction word.
REQ-015 rsp_err_o  output  1  request was misaligned or out of range.
REQ-016 ld_en_i  input  1  program-load write strobe.
REQ-017 ld_addr_i  input  AWIDTH  program-load byte address.
REQ-018 ld_data_i  input  DWIDTH  program-load word.

Function
REQ-019 Request accepted iff req_valid_i && req_ready_o at rising edge; response returned exactly once per accepted request, in acceptance order.
REQ-020 req_ready_o = (outstanding < QDEPTH), outstanding = in-flight pipeline entries + response-queue entries; response handed off at same edge frees a slot only from the next cycle.
REQ-021 Request accepted at edge N becomes visible at rsp_valid_o no earlier than after edge N+LATENCY; with rsp_ready_i held 1 and no backpressure, exactly N+LATENCY.
REQ-022 rsp_valid_o, rsp_data_o, rsp_err_o held stable while rsp_valid_o && !rsp_ready_i.
REQ-023 Index = (req_addr_i - BASEADDR) >> 2; rsp_err_o=1 and rsp_data_o=0 when req_addr_i[1:0] != 0, req_addr_i < BASEADDR, or req_addr_i >= BASEADDR + 4*DEPTH (computed without overflow at AWIDTH+1 bits).
REQ-024 Load writes memory at rising edge when ld_en_i=1 and ld_addr_i aligned and in range; misaligned/out-of-range loads ignored silently.
REQ-025 Read and load to same word in the same cycle: read returns pre-write contents.
REQ-026 Loads do not stall or alter req_ready_o.
REQ-027 Full: with outstanding == QDEPTH, req_ready_o=0; request held by initiator is not accepted and not duplicated.
REQ-028 Empty: with outstanding == 0, rsp_valid_o=0 and rsp_data_o/rsp_err_o = 0.
REQ-029 Simultaneous accept and handoff at QDEPTH-1 occupancy: both take effect, occupancy unchanged.
REQ-030 Response queue read/write pointers wrap modulo QDEPTH without loss or reorder.

Reset
REQ-031 rst asserted: immediately req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0; pipeline, queue pointers and counters cleared.
REQ-032 rst mid-operation discards all outstanding requests; no response for them is ever produced.
REQ-033 Memory array not reset; contents preserved across rst.
REQ-034 First cycle after rst deasserts: req_ready_o=1.

Structure
REQ-035 Shared package holds BASEADDR default, DWIDTH/AWIDTH defaults, and NOP constant 32'h00000013 used by benches.
REQ-036 Response queue is sub-module insn_mem_rspq (FIFO, DEPTH QDEPTH, {err,data} payload).
REQ-037 Storage is a DEPTH x DWIDTH array; pipeline is LATENCY stages of {valid,err,data}.

Verification
REQ-038 Load 0x00500093 at 0x01000000, 0x00100113 at 0x01000004; request both back-to-back, rsp_ready_i=1 -> responses at accept+2 in order, err=0.
REQ-039 Request 0x01000002 -> rsp_err_o=1, rsp_data_o=0; request 0x00FFFFFC and 0x01001000 -> rsp_err_o=1.
REQ-040 rsp_ready_i=0, issue 6 requests -> exactly 4 accepted, req_ready_o=0; release -> 4 responses in order, stable while stalled.
REQ-041 Same-cycle load 0xDEADBEEF and request to 0x01000008 holding 0x00000013 -> response 0x00000013; next request -> 0xDEADBEEF.
REQ-042 Assert rst with 3 outstanding -> rsp_valid_o=0 immediately, no stale responses after release, memory contents intact.
REQ-043 Random valid/ready streaming for 2000 cycles with pointer wrap -> scoreboard matches order and data, no drops.

Source files
------------

// File: rtl/insn_mem_pkg.sv
// Shared constants for the instruction memory: default widths, base address
// and the canonical NOP encoding used to pre-fill program images.
package insn_mem_pkg;

  localparam int          DWIDTH_DEF   = 32;
  localparam int          AWIDTH_DEF   = 32;
  localparam logic [31:0] BASEADDR_DEF = 32'h0100_0000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/insn_mem_rspq.sv
// Response queue: small circular FIFO holding {err,data} words until the
// fetch stage takes them. Overflow is prevented upstream by the outstanding
// counter, so push is never issued while full.
module insn_mem_rspq #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Payload storage written at the tail.
  // NOTE: storage arrays carry no reset; only pointers and count define
  // which entries are meaningful, and leaving the array unreset lets it map
  // to plain RAM/flops without reset routing.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

  // Head/tail pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= ptr_inc(r_wr);
      if (i_pop)  r_rd <= ptr_inc(r_rd);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_valid = (r_cnt != '0);
  // Empty queue presents an all-zero word rather than stale storage.
  assign o_dout  = o_valid ? r_mem[r_rd] : '0;

endmodule

// File: rtl/insn_mem.sv
// Instruction memory with valid/ready fetch port and a side program-load
// port. Reads pass through a fixed LATENCY-stage pipeline and land in a
// response queue; an outstanding counter bounds in-flight plus queued
// requests to QDEPTH so the queue can never overflow.
module insn_mem
  import insn_mem_pkg::*;
#(
  parameter int                DWIDTH   = DWIDTH_DEF,
  parameter int                AWIDTH   = AWIDTH_DEF,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEF),
  parameter int                DEPTH    = 1024,
  parameter int                LATENCY  = 2,
  parameter int                QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_data_o,
  output logic              rsp_err_o,
  input  logic              ld_en_i,
  input  logic [AWIDTH-1:0] ld_addr_i,
  input  logic [DWIDTH-1:0] ld_data_i
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  // Range limits carried at AWIDTH+1 bits so BASEADDR + 4*DEPTH cannot wrap.
  localparam logic [AWIDTH:0] BASE_X  = {1'b0, BASEADDR};
  localparam logic [AWIDTH:0] LIMIT_X = BASE_X + (AWIDTH+1)'(4 * DEPTH);

  function automatic logic addr_ok(input logic [AWIDTH-1:0] a);
    logic [AWIDTH:0] ax;
    ax = {1'b0, a};
    return (a[1:0] == 2'b00) && (ax >= BASE_X) && (ax < LIMIT_X);
  endfunction

  function automatic logic [IW-1:0] addr_idx(input logic [AWIDTH-1:0] a);
    logic [AWIDTH:0] off;
    off = {1'b0, a} - BASE_X;
    return IW'(off >> 2);
  endfunction

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic              r_pv  [LATENCY];
  logic              r_pe  [LATENCY];
  logic [DWIDTH-1:0] r_pd  [LATENCY];
  logic [CW-1:0]     r_out;

  logic              w_acc;
  logic              w_pop;
  logic              w_req_ok;
  logic              w_ld_ok;
  logic [IW-1:0]     w_req_idx;
  logic [IW-1:0]     w_ld_idx;
  logic [DWIDTH:0]   w_rsp_payload;

  assign w_req_ok  = addr_ok(req_addr_i);
  assign w_req_idx = addr_idx(req_addr_i);
  assign w_ld_ok   = addr_ok(ld_addr_i);
  assign w_ld_idx  = addr_idx(ld_addr_i);

  // Ready is forced low for the whole reset interval, not just after it.
  assign req_ready_o = !rst && (r_out < CW'(QDEPTH));
  assign w_acc       = req_valid_i && req_ready_o;
  assign w_pop       = rsp_valid_o && rsp_ready_i;

  // Program-load write port; bad addresses are dropped silently.
  always_ff @(posedge clk) begin
    if (ld_en_i && w_ld_ok) r_mem[w_ld_idx] <= ld_data_i;
  end

  // Read pipeline: stage 0 samples the array, later stages just delay.
  // NOTE: non-blocking assignments on both the array write and this read
  // make a same-edge load and fetch of one word return the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pe[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_acc;
      r_pe[0] <= !w_req_ok;
      r_pd[0] <= (w_acc && w_req_ok) ? r_mem[w_req_idx] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  // Outstanding = pipeline + queue occupancy; a handoff frees its slot
  // only after the edge it happens on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      case ({w_acc, w_pop})
        2'b10:   r_out <= r_out + CW'(1);
        2'b01:   r_out <= r_out - CW'(1);
        default: r_out <= r_out;
      endcase
    end
  end

  insn_mem_rspq #(
    .WIDTH (DWIDTH + 1),
    .DEPTH (QDEPTH)
  ) u_rspq (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pv[LATENCY-1]),
    .i_din   ({r_pe[LATENCY-1], r_pd[LATENCY-1]}),
    .i_pop   (w_pop),
    .o_valid (rsp_valid_o),
    .o_dout  (w_rsp_payload)
  );

  assign rsp_err_o  = w_rsp_payload[DWIDTH];
  assign rsp_data_o = w_rsp_payload[DWIDTH-1:0];

endmodule

// File: tb/tb_insn_mem.sv
// Directed plus randomized bench for insn_mem. Expected {err,data} words are
// queued when a request is accepted and compared by a monitor on handoff.
module tb_insn_mem;
  import insn_mem_pkg::*;

  localparam logic [31:0] BASE  = BASEADDR_DEF;
  localparam int          DEPTH = 1024;
  localparam int          QD    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;
  logic        ld_en_i;
  logic [31:0] ld_addr_i;
  logic [31:0] ld_data_i;

  insn_mem #(
    .DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE),
    .DEPTH(DEPTH), .LATENCY(2), .QDEPTH(QD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .ld_en_i(ld_en_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_rsp    = 0;
  logic [32:0] sb [$];
  logic [31:0] mdl [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    logic [32:0] ax;
    ax = {1'b0, a};
    return (a[1:0] == 2'b00) && (ax >= {1'b0, BASE}) && (ax < ({1'b0, BASE} + 33'd4096));
  endfunction

  function automatic logic [32:0] model_rd(input logic [31:0] a);
    if (!in_range(a)) return {1'b1, 32'h0};
    return {1'b0, mdl[10'((a - BASE) >> 2)]};
  endfunction

  task automatic model_ld(input logic [31:0] a, input logic [31:0] d);
    if (in_range(a)) mdl[10'((a - BASE) >> 2)] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en_i = 1'b1; ld_addr_i = a; ld_data_i = d;
    model_ld(a, d);
    tick();
    ld_en_i = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a);
    bit done;
    done = 0;
    req_valid_i = 1'b1; req_addr_i = a;
    for (int k = 0; k < 50 && !done; k++) begin
      if (req_ready_o) begin
        sb.push_back(model_rd(a));
        done = 1;
      end
      tick();
    end
    req_valid_i = 1'b0;
    check("issue_accepted", 64'(done), 64'd1);
  endtask

  task automatic drain();
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0 && !rsp_valid_o) break;
      tick();
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Handoff monitor and hold-while-stalled checker, sampled mid-cycle.
  logic        prev_stall = 1'b0;
  logic [32:0] prev_pl;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(rsp_valid_o), 64'd1);
        check("stall_payload", 64'({rsp_err_o, rsp_data_o}), 64'(prev_pl));
      end
      if (rsp_valid_o && rsp_ready_i) begin
        n_rsp++;
        if (sb.size() == 0) check("rsp_unexpected", 64'(sb.size()), 64'd1);
        else check("rsp_payload", 64'({rsp_err_o, rsp_data_o}), 64'(sb.pop_front()));
      end
      prev_stall = rsp_valid_o && !rsp_ready_i;
      prev_pl    = {rsp_err_o, rsp_data_o};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int rsp0;
    int acc_rand;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    rst = 1'b1; req_valid_i = 0; req_addr_i = '0; rsp_ready_i = 0;
    ld_en_i = 0; ld_addr_i = '0; ld_data_i = '0;

    // Reset state
    repeat (3) tick();
    check("rst_ready", 64'(req_ready_o), 64'd0);
    check("rst_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_data",  64'(rsp_data_o),  64'd0);
    check("rst_err",   64'(rsp_err_o),   64'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 64'(req_ready_o), 64'd1);
    tick();

    // Program image, then illegal loads that must be ignored
    for (int i = 0; i < 16; i++) load(BASE + 32'(4 * i), 32'h1000_0000 + 32'(i * 32'h0101));
    load(BASE,          32'h0050_0093);
    load(BASE + 32'd4,  32'h0010_0113);
    load(BASE + 32'd8,  NOP);
    load(BASE + 32'd4092, 32'hCAFE_F00D);
    load(BASE + 32'd1,  32'hBAD0_0001);
    load(BASE - 32'd4,  32'hBAD0_0002);
    load(BASE + 32'd4096, 32'hBAD0_0003);
    check("empty_valid", 64'(rsp_valid_o), 64'd0);
    check("empty_data",  64'(rsp_data_o),  64'd0);
    check("empty_err",   64'(rsp_err_o),   64'd0);

    // Back-to-back fetch, latency 2
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = BASE;
    check("b2b_ready0", 64'(req_ready_o), 64'd1);
    sb.push_back(model_rd(BASE));
    tick();
    req_addr_i = BASE + 32'd4;
    check("b2b_ready1", 64'(req_ready_o), 64'd1);
    sb.push_back(model_rd(BASE + 32'd4));
    tick();
    req_valid_i = 1'b0;
    check("lat_n1_valid", 64'(rsp_valid_o), 64'd0);
    tick();
    check("lat_n2_valid", 64'(rsp_valid_o), 64'd1);
    check("lat_n2_word",  64'({rsp_err_o, rsp_data_o}), 64'({1'b0, 32'h0050_0093}));
    tick();
    check("lat_n3_valid", 64'(rsp_valid_o), 64'd1);
    check("lat_n3_word",  64'({rsp_err_o, rsp_data_o}), 64'({1'b0, 32'h0010_0113}));
    drain();

    // Error cases and top-of-range word
    issue(BASE + 32'd2);
    issue(BASE - 32'd4);
    issue(BASE + 32'd4096);
    issue(BASE + 32'd4092);
    issue(BASE);
    drain();

    // Full queue under backpressure
    rsp_ready_i = 1'b0;
    acc = 0;
    req_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_addr_i = BASE + 32'(4 * i);
      if (req_ready_o) begin
        sb.push_back(model_rd(req_addr_i));
        acc++;
      end
      tick();
    end
    check("full_accepted", 64'(acc), 64'd4);
    check("full_ready", 64'(req_ready_o), 64'd0);
    req_valid_i = 1'b0;
    repeat (4) tick();
    check("full_valid_held", 64'(rsp_valid_o), 64'd1);
    drain();

    // Simultaneous accept and handoff at QDEPTH-1 occupancy
    rsp_ready_i = 1'b0;
    issue(BASE + 32'd12);
    issue(BASE + 32'd16);
    issue(BASE + 32'd20);
    repeat (3) tick();
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = BASE + 32'd24;
    check("sim_ready_before", 64'(req_ready_o), 64'd1);
    sb.push_back(model_rd(BASE + 32'd24));
    tick();
    req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    check("sim_ready_after", 64'(req_ready_o), 64'd1);
    issue(BASE + 32'd28);
    check("sim_ready_full", 64'(req_ready_o), 64'd0);
    drain();

    // Same-cycle load and fetch of one word
    rsp_ready_i = 1'b1;
    ld_en_i = 1'b1; ld_addr_i = BASE + 32'd8; ld_data_i = 32'hDEAD_BEEF;
    req_valid_i = 1'b1; req_addr_i = BASE + 32'd8;
    check("rw_ready", 64'(req_ready_o), 64'd1);
    sb.push_back(model_rd(BASE + 32'd8));
    model_ld(BASE + 32'd8, 32'hDEAD_BEEF);
    tick();
    ld_en_i = 1'b0; req_valid_i = 1'b0;
    issue(BASE + 32'd8);
    drain();

    // Reset with outstanding requests
    rsp_ready_i = 1'b0;
    issue(BASE);
    issue(BASE + 32'd4);
    issue(BASE + 32'd12);
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(rsp_valid_o), 64'd0);
    check("midrst_ready", 64'(req_ready_o), 64'd0);
    check("midrst_data",  64'(rsp_data_o),  64'd0);
    check("midrst_err",   64'(rsp_err_o),   64'd0);
    sb.delete();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("midrst_release_ready", 64'(req_ready_o), 64'd1);
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_stale", 64'(rsp_valid_o), 64'd0);
    end
    issue(BASE);
    issue(BASE + 32'd8);
    drain();

    // Random streaming with loads
    rsp0 = n_rsp;
    acc_rand = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      req_valid_i = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 15))
        0:       a = BASE + 32'd4096 + 32'(4 * $urandom_range(0, 3));
        1:       a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        default: a = BASE + 32'(4 * $urandom_range(0, 15));
      endcase
      req_addr_i = a;
      ld_en_i   = ($urandom_range(0, 7) == 0);
      ld_addr_i = ($urandom_range(0, 7) == 0) ? BASE - 32'd4 : BASE + 32'(4 * $urandom_range(0, 15));
      ld_data_i = $urandom;
      if (req_valid_i && req_ready_o) begin
        sb.push_back(model_rd(a));
        acc_rand++;
      end
      if (ld_en_i) model_ld(ld_addr_i, ld_data_i);
      tick();
    end
    req_valid_i = 1'b0; ld_en_i = 1'b0;
    drain();
    check("rand_count", 64'(n_rsp - rsp0), 64'(acc_rand));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
